// File: rtl/param_multicycle_core.sv
// Multicycle CPU core with a configurable data width and register count.
// Instruction fetch and data access share one req/ack memory port.
//
// state    | meaning
// S_FETCH  | request instruction at PC; on ack latch IR, PC+1
// S_DECODE | read rs/rt into A/B; trap illegal opcodes, stop on HALT
// S_EXEC   | ALU or effective address into ALUout; resolve branch/jump
// S_MEM    | data access at ALUout (store of B or load into MDR)
// S_WB     | register file write from ALUout or MDR
// S_HALT   | stopped; only reset leaves this state
module param_multicycle_core #(
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);
    localparam int RW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_aluout;
    logic [DATA_W-1:0] r_mdr;
    logic              r_illegal;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [5:0]        w_op;
    logic [3:0]        w_f;
    logic [RW-1:0]     w_rs;
    logic [RW-1:0]     w_rt;
    logic [RW-1:0]     w_rd;
    logic [RW-1:0]     w_wr_idx;
    logic [RW-1:0]     w_dbg_idx;
    logic [15:0]       w_imm;
    logic [31:0]       w_instr;
    logic              w_is_ralu;
    logic              w_is_ialu;
    logic              w_is_beq;
    logic              w_is_bne;
    logic              w_is_lw;
    logic              w_is_sw;
    logic              w_is_j;
    logic              w_is_halt;
    logic              w_legal;
    logic              w_take;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_ext_imm;
    logic [DATA_W-1:0] w_alu_b;
    logic [3:0]        w_alu_f;
    logic [6:0]        w_shamt;
    logic [DATA_W-1:0] w_alu_y;
    logic [ADDR_W-1:0] w_ea;
    logic [ADDR_W-1:0] w_target;

    assign w_op      = r_ir[31:26];
    assign w_f       = w_op[3:0];
    assign w_rs      = r_ir[21 +: RW];
    assign w_rt      = r_ir[16 +: RW];
    assign w_rd      = r_ir[11 +: RW];
    assign w_imm     = r_ir[15:0];
    assign w_instr   = 32'(mem_rdata);
    assign w_dbg_idx = dbg_raddr[RW-1:0];

    assign w_is_ralu = (w_op[5:4] == 2'b00) && (w_f <= 4'd10);
    assign w_is_ialu = (w_op[5:4] == 2'b01) && (w_f <= 4'd10);
    assign w_is_beq  = (w_op == 6'b100000);
    assign w_is_bne  = (w_op == 6'b100001);
    assign w_is_lw   = (w_op == 6'b110000);
    assign w_is_sw   = (w_op == 6'b110001);
    assign w_is_j    = (w_op == 6'b111000);
    assign w_is_halt = (w_op == 6'b111111);
    assign w_legal   = w_is_ralu | w_is_ialu | w_is_beq | w_is_bne |
                       w_is_lw | w_is_sw | w_is_j | w_is_halt;
    assign w_take    = (w_is_beq && (r_a == r_b)) || (w_is_bne && (r_a != r_b)) || w_is_j;

    assign w_sext    = DATA_W'($signed(w_imm));
    assign w_zext    = DATA_W'(w_imm);
    assign w_ext_imm = (w_f <= 4'd3 || w_f == 4'd7) ? w_sext : w_zext;
    assign w_ea      = ADDR_W'(r_aluout);
    assign w_target  = ADDR_W'(w_imm);
    assign w_wr_idx  = w_is_ralu ? w_rd : w_rt;

    // Loads and stores reuse the adder with a sign-extended offset.
    always_comb begin
        w_alu_b = r_b;
        w_alu_f = w_f;
        if (w_is_lw || w_is_sw) begin
            w_alu_b = w_sext;
            w_alu_f = 4'd0;
        end else if (w_is_ialu) begin
            w_alu_b = w_ext_imm;
        end
        w_shamt = 7'(w_alu_b % DATA_W'(DATA_W));
        case (w_alu_f)
            4'd0:    w_alu_y = r_a + w_alu_b;
            4'd1:    w_alu_y = r_a - w_alu_b;
            4'd2:    w_alu_y = DATA_W'($signed(r_a) < $signed(w_alu_b));
            4'd3:    w_alu_y = DATA_W'(r_a < w_alu_b);
            4'd4:    w_alu_y = r_a & w_alu_b;
            4'd5:    w_alu_y = r_a | w_alu_b;
            4'd6:    w_alu_y = r_a ^ w_alu_b;
            4'd7:    w_alu_y = w_alu_b;
            4'd8:    w_alu_y = r_a << w_shamt;
            4'd9:    w_alu_y = r_a >> w_shamt;
            4'd10:   w_alu_y = $signed(r_a) >>> w_shamt;
            default: w_alu_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_pc;
        mem_wdata = r_b;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (!w_legal || w_is_halt) w_next = S_HALT;
                else                       w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_is_lw || w_is_sw)          w_next = S_MEM;
                else if (w_is_ralu || w_is_ialu) w_next = S_WB;
                else                             w_next = S_FETCH;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = w_is_sw;
                mem_addr = w_ea;
                if (mem_ack) w_next = w_is_lw ? S_WB : S_FETCH;
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
        // The request must vanish immediately while reset is held.
        if (!rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_aluout  <= '0;
            r_mdr     <= '0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir <= w_instr;
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                    if (!w_legal) r_illegal <= 1'b1;
                end
                S_EXEC: begin
                    r_aluout <= w_alu_y;
                    if (w_take) r_pc <= w_target;
                end
                S_MEM: begin
                    if (mem_ack && w_is_lw) r_mdr <= mem_rdata;
                end
                S_WB: begin
                    if (w_wr_idx != '0) r_regs[w_wr_idx] <= w_is_lw ? r_mdr : r_aluout;
                end
                default: ;
            endcase
        end
    end

    assign dbg_rdata = r_regs[w_dbg_idx];
    assign pc        = r_pc;
    assign halted    = (r_state == S_HALT);
    assign illegal   = r_illegal;
endmodule

// File: tb/tb_param_multicycle_core.sv
// Bench for param_multicycle_core: an instruction-level reference model predicts
// every memory access (with its start cycle), final registers, PC and flags.
module tb_param_multicycle_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata;
    logic [15:0] pc;
    logic        halted, illegal;

    always #5 clk = ~clk;

    param_multicycle_core dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .pc(pc), .halted(halted), .illegal(illegal)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          wt;
        int          start;
    } acc_t;

    logic [31:0] tb_mem [0:65535];
    logic [31:0] m_mem  [0:65535];
    acc_t        exp_q[$];
    logic [31:0] exp_r [32];
    logic [15:0] exp_pc;
    logic        exp_ill;
    int          exp_halt;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input int idx, input logic [31:0] exp);
        dbg_raddr = 5'(idx);
        #1;
        chk($sformatf("r%0d", idx), dbg_rdata, exp);
    endtask

    // Memory responder: serves accesses in the order the model predicted them,
    // inserting that access's wait cycles and checking the request each cycle.
    int ncyc = 0;
    int wcnt = 0;
    bit in_acc = 0;
    always @(negedge clk) begin
        if (!rst) begin
            mem_ack = 1'b1;
            in_acc  = 0;
            ncyc    = 0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", mem_req, 1'b0);
                end else begin
                    if (!in_acc) begin
                        chk("acc_start_cyc", 64'(ncyc), 64'(exp_q[0].start));
                        in_acc = 1;
                        wcnt   = 0;
                    end
                    chk("mem_addr", mem_addr, exp_q[0].addr);
                    chk("mem_we", mem_we, exp_q[0].we);
                    if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                    if (wcnt == exp_q[0].wt) begin
                        mem_ack   = 1'b1;
                        mem_rdata = tb_mem[mem_addr];
                        if (mem_we) tb_mem[mem_addr] = mem_wdata;
                        void'(exp_q.pop_front());
                        in_acc = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end
            ncyc++;
        end
    end

    function automatic logic [31:0] ext(input logic [3:0] f, input logic [15:0] imm);
        if (f inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7}) return {{16{imm[15]}}, imm};
        return {16'h0, imm};
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd7:  return b;
            4'd8:  return a << sh;
            4'd9:  return a >> sh;
            4'd10: return 32'(longint'(int'(a)) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // mode 0: zero-wait, 1: data accesses wait 3, 2: random 0..2 waits everywhere
    function automatic int pick_wait(input int mode, input bit is_data);
        if (mode == 1) return is_data ? 3 : 0;
        if (mode == 2) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    task automatic model(input int mode);
        logic [31:0] r [32];
        logic [15:0] p, ea;
        logic [31:0] ir, a, b;
        logic [5:0]  op;
        logic [4:0]  dst;
        int          c, w;
        acc_t        e;
        for (int i = 0; i < 32; i++) r[i] = '0;
        p = 16'h0; c = 0; exp_ill = 1'b0; exp_halt = -1;
        for (int step = 0; step < 500; step++) begin
            w = pick_wait(mode, 1'b0);
            e = '{addr: p, we: 1'b0, wdata: 32'h0, wt: w, start: c};
            exp_q.push_back(e);
            ir = m_mem[p]; p = p + 16'd1; c = c + w;
            op = ir[31:26]; a = r[ir[25:21]]; b = r[ir[20:16]];
            if (op == 6'h3F) begin
                exp_halt = c + 2;
                break;
            end else if (op[5] == 1'b0 && op[3:0] <= 4'd10) begin
                dst = op[4] ? ir[20:16] : ir[15:11];
                if (dst != 5'd0) r[dst] = alu(op[3:0], a, op[4] ? ext(op[3:0], ir[15:0]) : b);
                c = c + 4;
            end else if (op == 6'h20 || op == 6'h21) begin
                if ((a == b) == (op == 6'h20)) p = ir[15:0];
                c = c + 3;
            end else if (op == 6'h38) begin
                p = ir[15:0];
                c = c + 3;
            end else if (op == 6'h30 || op == 6'h31) begin
                ea = 16'(a + {{16{ir[15]}}, ir[15:0]});
                w  = pick_wait(mode, 1'b1);
                e  = '{addr: ea, we: (op == 6'h31), wdata: b, wt: w, start: c + 3};
                exp_q.push_back(e);
                if (op == 6'h31) begin
                    m_mem[ea] = b;
                    c = c + 4 + w;
                end else begin
                    if (ir[20:16] != 5'd0) r[ir[20:16]] = m_mem[ea];
                    c = c + 5 + w;
                end
            end else begin
                exp_ill  = 1'b1;
                exp_halt = c + 2;
                break;
            end
        end
        for (int i = 0; i < 32; i++) exp_r[i] = r[i];
        exp_pc = p;
    endtask

    task automatic run_test(input int mode);
        bit found;
        int budget;
        exp_q.delete();
        m_mem = tb_mem;
        model(mode);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_pc", pc, 16'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        found  = 0;
        budget = (exp_halt < 0) ? 5000 : exp_halt + 40;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) begin
                found = 1;
                chk("halt_cycle", 64'(i), 64'(exp_halt));
                break;
            end
        end
        if (!found) chk("halt_reached", halted, 1'b1);
        chk("pending_accesses", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("final_pc", pc, exp_pc);
        chk("final_illegal", illegal, exp_ill);
        for (int i = 0; i < 32; i++) chk_reg(i, exp_r[i]);
        repeat (10) begin
            @(negedge clk);
            chk("halt_no_req", mem_req, 1'b0);
        end
    endtask

    task automatic gen_prog();
        int n, k, tgt;
        logic [4:0]  rs, rt, rd;
        logic [3:0]  f;
        logic [15:0] off;
        n = 20 + int'($urandom_range(0, 8));
        for (int a = 0; a < 256; a++) tb_mem[a] = '0;
        for (int a = 256; a < 320; a++) tb_mem[a] = $urandom;
        for (int i = 0; i < n - 1; i++) begin
            k   = int'($urandom_range(0, 9));
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            f   = 4'($urandom_range(0, 10));
            off = 16'h100 + 16'($urandom_range(0, 63));
            tgt = int'($urandom_range(i + 1, n - 1));
            case (k)
                0, 1, 2, 3: tb_mem[i] = {2'b00, f, rs, rt, rd, 11'($urandom)};
                4, 5:       tb_mem[i] = {2'b01, f, rs, rt, 16'($urandom)};
                6:          tb_mem[i] = {6'b110000, rs, rt, off};
                7:          tb_mem[i] = {6'b110001, 5'd0, rt, off};
                8:          tb_mem[i] = {5'b10000, 1'($urandom_range(0, 1)), rs, rt, 16'(tgt)};
                default:    tb_mem[i] = {6'b111000, 10'd0, 16'(tgt)};
            endcase
        end
        tb_mem[n - 1] = ($urandom_range(0, 3) == 0) ? 32'h3000_0000 : 32'hFC00_0000;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) tb_mem[a] = '0;

        tb_mem[0]     = 32'h4001_0005;
        tb_mem[1]     = 32'h0021_1000;
        tb_mem[2]     = 32'h4003_FFFF;
        tb_mem[3]     = 32'h5404_FFFF;
        tb_mem[4]     = 32'h4000_0007;
        tb_mem[5]     = 32'hC402_0020;
        tb_mem[6]     = 32'hC005_0020;
        tb_mem[7]     = 32'h8021_0010;
        tb_mem[16]    = 32'h8421_0005;
        tb_mem[17]    = 32'hE000_0030;
        tb_mem[48]    = 32'hFC00_0000;
        run_test(1);
        chk_reg(0, 32'h0);
        chk_reg(1, 32'h5);
        chk_reg(2, 32'hA);
        chk_reg(3, 32'hFFFF_FFFF);
        chk_reg(4, 32'h0000_FFFF);
        chk_reg(5, 32'hA);
        chk("dir_pc", pc, 16'h0031);
        chk("dir_halted", halted, 1'b1);
        chk("dir_illegal", illegal, 1'b0);
        chk("dir_store", tb_mem[32], 32'hA);

        for (int a = 0; a < 256; a++) tb_mem[a] = '0;
        tb_mem[0] = 32'hA000_0000;
        run_test(0);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_halted", halted, 1'b1);
        chk("ill_pc", pc, 16'h0001);

        for (int t = 0; t < 8; t++) begin
            gen_prog();
            run_test((t % 2 == 0) ? 0 : 2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
